// File: rtl/pcie_cc_chan_arb.sv
// Multi-channel PCIe completer-completion arbiter: per-channel show-ahead FIFOs, packet-level round-robin onto s_axis_cc.
// Optional beat capture port enabled by defining PCIE_CC_CAP_EN.
module pcie_cc_chan_arb #(
    parameter int DWIDTH  = 256,
    parameter int CHAN    = 4,
    parameter int FIFO_AW = 5
) (
    input  logic                     pcie_clk_i,
    input  logic                     pcie_rst_i,
    input  logic                     pcie_link_up_i,
    input  logic [CHAN*DWIDTH-1:0]   ch_data_i,
    input  logic [CHAN*16-1:0]       ch_data_ex_i,
    input  logic [CHAN-1:0]          ch_wen_i,
    output logic [CHAN-1:0]          ch_ready_o,
    output logic [DWIDTH-1:0]        s_axis_cc_tdata_o,
    output logic [32:0]              s_axis_cc_tuser_o,
    output logic                     s_axis_cc_tlast_o,
    output logic [DWIDTH/32-1:0]     s_axis_cc_tkeep_o,
    output logic                     s_axis_cc_tvalid_o,
    input  logic                     s_axis_cc_tready_i,
    output logic [15:0]              odbg_info_o
`ifdef PCIE_CC_CAP_EN
    ,
    output logic [DWIDTH-1:0]        cap_cc_data_o,
    output logic                     cap_cc_wen_o
`endif
);

    localparam int KW    = DWIDTH / 32;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = DWIDTH + 7;
    localparam int CW    = (CHAN > 1) ? $clog2(CHAN) : 1;
    localparam logic [FIFO_AW:0] READY_MARK = (FIFO_AW+1)'(DEPTH - 4);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           gnt_q, gnt_d;
    logic [CW-1:0]           rrPtr_q, rrPtr_d;
    logic [7:0]              pktCnt_q, pktCnt_d;
    logic [CHAN-1:0]         fifoEmpty;
    logic [CHAN-1:0]         chReady;
    logic [CHAN-1:0]         ovfBits;
    logic [CHAN-1:0][FW-1:0] headWord;
    logic [FW-1:0]           headSel;
    logic                    headEop;
    logic                    headErr;
    logic [4:0]              headKeep;
    logic                    tvalid;
    logic                    popBeat;
    logic [CW-1:0]           pick;
    logic                    pickValid;
    logic [3:0]              ovfPad;

    // Each FIFO word packs {EOP, ERR, KEEP[4:0], data}; SOP is implied by packet framing.
    for (genvar g = 0; g < CHAN; g++) begin : gFifo
        logic [FW-1:0]    mem_q [DEPTH];
        logic [FIFO_AW:0] wrPtr_q;
        logic [FIFO_AW:0] rdPtr_q;
        logic             ready_q;
        logic             ovf_q;
        logic [FIFO_AW:0] used;
        logic             full;
        logic             doWrite;
        logic             doPop;
        logic             unusedSideband;

        assign used    = wrPtr_q - rdPtr_q;
        assign full    = used[FIFO_AW];
        assign doWrite = ch_wen_i[g] && !full;
        assign doPop   = popBeat && (gnt_q == CW'(g));
        assign unusedSideband = ^{ch_data_ex_i[g*16+15], ch_data_ex_i[g*16 +: 8]};

        always_ff @(posedge pcie_clk_i) begin
            if (doWrite) begin
                mem_q[wrPtr_q[FIFO_AW-1:0]] <= {ch_data_ex_i[g*16+14], ch_data_ex_i[g*16+13],
                                                ch_data_ex_i[g*16+8 +: 5], ch_data_i[g*DWIDTH +: DWIDTH]};
            end
        end

        always_ff @(posedge pcie_clk_i or posedge pcie_rst_i) begin
            if (pcie_rst_i) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                ready_q <= 1'b1;
                ovf_q   <= 1'b0;
            end else begin
                if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
                if (doPop)   rdPtr_q <= rdPtr_q + 1'b1;
                if (ch_wen_i[g] && full) ovf_q <= 1'b1;
                ready_q <= (used < READY_MARK);
            end
        end

        assign fifoEmpty[g] = (used == '0);
        assign headWord[g]  = mem_q[rdPtr_q[FIFO_AW-1:0]];
        assign chReady[g]   = ready_q;
        assign ovfBits[g]   = ovf_q;
    end

    assign headSel  = headWord[gnt_q];
    assign headEop  = headSel[FW-1];
    assign headErr  = headSel[FW-2];
    assign headKeep = headSel[DWIDTH +: 5];
    assign tvalid   = (state_q == BUSY) && !fifoEmpty[gnt_q];
    assign popBeat  = tvalid && s_axis_cc_tready_i;

    // First nonempty channel at or after the round-robin pointer; the lowest offset wins.
    always_comb begin
        int idx;
        pick      = '0;
        pickValid = 1'b0;
        idx       = 0;
        for (int i = CHAN - 1; i >= 0; i--) begin
            idx = int'(rrPtr_q) + i;
            if (idx >= CHAN) idx = idx - CHAN;
            if (!fifoEmpty[CW'(idx)]) begin
                pick      = CW'(idx);
                pickValid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rrPtr_d  = rrPtr_q;
        pktCnt_d = pktCnt_q;
        case (state_q)
            IDLE: begin
                if (pcie_link_up_i && pickValid) begin
                    gnt_d   = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (popBeat && headEop) begin
                    state_d  = IDLE;
                    rrPtr_d  = (gnt_q == CW'(CHAN - 1)) ? '0 : gnt_q + 1'b1;
                    pktCnt_d = pktCnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge pcie_clk_i or posedge pcie_rst_i) begin
        if (pcie_rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rrPtr_q  <= '0;
            pktCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rrPtr_q  <= rrPtr_d;
            pktCnt_q <= pktCnt_d;
        end
    end

    // A partial keep applies only to the EOP beat; zero or out-of-range counts mean a full beat.
    always_comb begin
        s_axis_cc_tkeep_o = '1;
        if (headEop && (headKeep != 5'd0) && ({27'd0, headKeep} < 32'(KW))) begin
            s_axis_cc_tkeep_o = KW'((32'd1 << headKeep) - 32'd1);
        end
    end

    always_comb begin
        ovfPad             = '0;
        ovfPad[CHAN-1:0]   = ovfBits;
    end

    assign ch_ready_o         = chReady;
    assign s_axis_cc_tdata_o  = headSel[DWIDTH-1:0];
    assign s_axis_cc_tuser_o  = {32'h0, headErr};
    assign s_axis_cc_tlast_o  = headEop;
    assign s_axis_cc_tvalid_o = tvalid;
    assign odbg_info_o        = {pktCnt_q, ovfPad, (state_q == BUSY), tvalid,
                                 s_axis_cc_tready_i, ~&fifoEmpty};

`ifdef PCIE_CC_CAP_EN
    logic [DWIDTH-1:0] capData_q;
    logic              capWen_q;

    always_ff @(posedge pcie_clk_i or posedge pcie_rst_i) begin
        if (pcie_rst_i) begin
            capData_q <= '0;
            capWen_q  <= 1'b0;
        end else begin
            capWen_q <= popBeat;
            if (popBeat) capData_q <= headSel[DWIDTH-1:0];
        end
    end

    assign cap_cc_data_o = capData_q;
    assign cap_cc_wen_o  = capWen_q;
`endif

endmodule

// File: tb/tb_pcie_cc_chan_arb.sv
// Directed self-checking bench for pcie_cc_chan_arb (DWIDTH=256, CHAN=4, FIFO_AW=5).
module tb_pcie_cc_chan_arb;

    localparam int DW = 256;
    localparam int CH = 4;
    localparam int AW = 5;

    logic              pcie_clk = 1'b0;
    logic              pcie_rst = 1'b1;
    logic              link     = 1'b1;
    logic [CH*DW-1:0]  ch_data  = '0;
    logic [CH*16-1:0]  ch_ex    = '0;
    logic [CH-1:0]     ch_wen   = '0;
    logic [CH-1:0]     ch_ready;
    logic [DW-1:0]     tdata;
    logic [32:0]       tuser;
    logic              tlast;
    logic [DW/32-1:0]  tkeep;
    logic              tvalid;
    logic              tready   = 1'b1;
    logic [15:0]       odbg;
`ifdef PCIE_CC_CAP_EN
    logic [DW-1:0]     capData;
    logic              capWen;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cycleCnt    = 0;

    logic [255:0] capQData [$];
    logic         capQLast [$];
    logic [7:0]   capQKeep [$];
    logic [32:0]  capQUser [$];
    int           capQCyc  [$];

    pcie_cc_chan_arb #(.DWIDTH(DW), .CHAN(CH), .FIFO_AW(AW)) dut (
        .pcie_clk_i         (pcie_clk),
        .pcie_rst_i         (pcie_rst),
        .pcie_link_up_i     (link),
        .ch_data_i          (ch_data),
        .ch_data_ex_i       (ch_ex),
        .ch_wen_i           (ch_wen),
        .ch_ready_o         (ch_ready),
        .s_axis_cc_tdata_o  (tdata),
        .s_axis_cc_tuser_o  (tuser),
        .s_axis_cc_tlast_o  (tlast),
        .s_axis_cc_tkeep_o  (tkeep),
        .s_axis_cc_tvalid_o (tvalid),
        .s_axis_cc_tready_i (tready),
        .odbg_info_o        (odbg)
`ifdef PCIE_CC_CAP_EN
        ,
        .cap_cc_data_o      (capData),
        .cap_cc_wen_o       (capWen)
`endif
    );

    always #5 pcie_clk = ~pcie_clk;

    always @(posedge pcie_clk) cycleCnt = cycleCnt + 1;

    // Record every accepted beat half a cycle before the edge that consumes it.
    always @(negedge pcie_clk) begin
        if (!pcie_rst && tvalid && tready) begin
            capQData.push_back(tdata);
            capQLast.push_back(tlast);
            capQKeep.push_back(tkeep);
            capQUser.push_back(tuser);
            capQCyc.push_back(cycleCnt);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] mkData(input int ch, input int pkt, input int beat);
        logic [31:0] tag;
        tag = {8'(ch), 8'(pkt), 16'(beat)};
        return {8{tag}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic clearCaps();
        capQData.delete();
        capQLast.delete();
        capQKeep.delete();
        capQUser.delete();
        capQCyc.delete();
    endtask

    task automatic setBeat(input int ch, input logic [255:0] data, input logic sop,
                           input logic eop, input logic err, input logic [4:0] keep);
        ch_data[ch*DW +: DW] = data;
        ch_ex[ch*16 +: 16]   = {sop, eop, err, keep, 8'h00};
        ch_wen[ch]           = 1'b1;
    endtask

    // Writes one packet of n beats into channel ch, one beat per cycle, EOP on the last.
    task automatic applyStimulus(input int ch, input int pkt, input int n,
                                 input logic [4:0] keep, input logic err);
        for (int b = 0; b < n; b++) begin
            setBeat(ch, mkData(ch, pkt, b), b == 0, b == n - 1, err, keep);
            step();
        end
        ch_wen = '0;
    endtask

    task automatic waitCaptures(input int n, input int budget);
        int k;
        k = 0;
        while (capQData.size() < n && k < budget) begin
            step();
            k++;
        end
        checkOutput("capture_count", 256'(capQData.size()), 256'(n));
    endtask

    task automatic pulseReset();
        pcie_rst = 1'b1;
        step();
        step();
        pcie_rst = 1'b0;
    endtask

    initial begin
        int startCyc;
        int e;

        // Reset values
        step();
        checkOutput("rst_tvalid", 256'(tvalid), 256'(1'b0));
        checkOutput("rst_ready", 256'(ch_ready), 256'(4'hf));
        checkOutput("rst_odbg", 256'(odbg), 256'(16'h0002));
        pcie_rst = 1'b0;
        step();

        // Test 1: single 3-beat packet on ch0, KEEP=3
        clearCaps();
        startCyc = cycleCnt;
        applyStimulus(0, 1, 3, 5'd3, 1'b0);
        waitCaptures(3, 20);
        checkOutput("t1_latency", 256'(capQCyc[0]), 256'(startCyc + 2));
        checkOutput("t1_contig1", 256'(capQCyc[1]), 256'(startCyc + 3));
        checkOutput("t1_contig2", 256'(capQCyc[2]), 256'(startCyc + 4));
        for (int b = 0; b < 3; b++) begin
            checkOutput($sformatf("t1_data%0d", b), capQData[b], mkData(0, 1, b));
        end
        checkOutput("t1_keep0", 256'(capQKeep[0]), 256'(8'hff));
        checkOutput("t1_keep1", 256'(capQKeep[1]), 256'(8'hff));
        checkOutput("t1_keep2", 256'(capQKeep[2]), 256'(8'h07));
        checkOutput("t1_last1", 256'(capQLast[1]), 256'(1'b0));
        checkOutput("t1_last2", 256'(capQLast[2]), 256'(1'b1));
        checkOutput("t1_pktcnt", 256'(odbg[15:8]), 256'(8'd1));
        checkOutput("t1_idle_tvalid", 256'(tvalid), 256'(1'b0));

        // Test 2: four preloaded 2-beat packets drain in channel order from rr=0
        pulseReset();
        clearCaps();
        for (int b = 0; b < 2; b++) begin
            setBeat(0, mkData(0, 2, b), b == 0, b == 1, 1'b0, 5'd0);
            setBeat(1, mkData(1, 2, b), b == 0, b == 1, 1'b0, 5'd7);
            setBeat(2, mkData(2, 2, b), b == 0, b == 1, 1'b0, 5'd8);
            setBeat(3, mkData(3, 2, b), b == 0, b == 1, 1'b0, 5'd1);
            step();
        end
        ch_wen = '0;
        waitCaptures(8, 40);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t2_data%0d", k), capQData[k], mkData(k / 2, 2, k % 2));
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t2_contig%0d", k), 256'(capQCyc[2*k+1] - capQCyc[2*k]), 256'(1));
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("t2_gap%0d", k), 256'(capQCyc[2*k+2] - capQCyc[2*k+1]), 256'(2));
        end
        checkOutput("t2_keep_ch0", 256'(capQKeep[1]), 256'(8'hff));
        checkOutput("t2_keep_ch1", 256'(capQKeep[3]), 256'(8'h7f));
        checkOutput("t2_keep_ch2", 256'(capQKeep[5]), 256'(8'hff));
        checkOutput("t2_keep_ch3", 256'(capQKeep[7]), 256'(8'h01));
        clearCaps();
        setBeat(0, mkData(0, 5, 0), 1'b1, 1'b1, 1'b0, 5'd0);
        setBeat(1, mkData(1, 5, 0), 1'b1, 1'b1, 1'b0, 5'd0);
        step();
        ch_wen = '0;
        waitCaptures(2, 20);
        checkOutput("t2_rr_first", capQData[0], mkData(0, 5, 0));
        checkOutput("t2_rr_second", capQData[1], mkData(1, 5, 0));

        // Test 3: ch2 fills with tready low; ready threshold and overflow
        clearCaps();
        tready = 1'b0;
        for (int b = 0; b < 33; b++) begin
            setBeat(2, mkData(2, 3, b), b == 0, b >= 31, 1'b0, 5'd0);
            step();
            if (b == 27) checkOutput("t3_ready_at28", 256'(ch_ready[2]), 256'(1'b1));
            if (b == 28) checkOutput("t3_ready_at29", 256'(ch_ready[2]), 256'(1'b0));
            if (b == 31) checkOutput("t3_ovf_before", 256'(odbg[6]), 256'(1'b0));
        end
        ch_wen = '0;
        checkOutput("t3_ovf_after", 256'(odbg[6]), 256'(1'b1));
        checkOutput("t3_ovf_others", 256'({odbg[7], odbg[5:4]}), 256'(3'b000));
        tready = 1'b1;
        waitCaptures(32, 60);
        for (int b = 0; b < 32; b++) begin
            checkOutput($sformatf("t3_data%0d", b), capQData[b], mkData(2, 3, b));
        end
        checkOutput("t3_last31", 256'(capQLast[31]), 256'(1'b1));
        checkOutput("t3_last30", 256'(capQLast[30]), 256'(1'b0));
        step();
        step();
        checkOutput("t3_no_extra", 256'(capQData.size()), 256'(32));
        checkOutput("t3_ready_back", 256'(ch_ready[2]), 256'(1'b1));

        // Test 4: tready toggles mid-packet, head must stay stable
        clearCaps();
        tready = 1'b0;
        applyStimulus(0, 4, 4, 5'd9, 1'b1);
        checkOutput("t4_tuser", 256'(tuser), 256'(33'h1));
        e = 0;
        for (int i = 0; i < 8; i++) begin
            tready = (i % 2 == 1);
            step();
            if (tready) e++;
            if (e < 4) begin
                checkOutput($sformatf("t4_valid%0d", i), 256'(tvalid), 256'(1'b1));
                checkOutput($sformatf("t4_data%0d", i), tdata, mkData(0, 4, e));
            end
        end
        checkOutput("t4_end_tvalid", 256'(tvalid), 256'(1'b0));
        checkOutput("t4_count", 256'(capQData.size()), 256'(4));
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("t4_cap%0d", b), capQData[b], mkData(0, 4, b));
        end
        checkOutput("t4_keep3", 256'(capQKeep[3]), 256'(8'hff));
        checkOutput("t4_user3", 256'(capQUser[3]), 256'(33'h1));

        // Test 5: link drops during ch1 packet; ch3 waits for link
        clearCaps();
        tready = 1'b0;
        applyStimulus(1, 5, 3, 5'd2, 1'b0);
        checkOutput("t5_busy_valid", 256'(tvalid), 256'(1'b1));
        link = 1'b0;
        applyStimulus(3, 5, 1, 5'd0, 1'b0);
        tready = 1'b1;
        waitCaptures(3, 20);
        for (int b = 0; b < 3; b++) begin
            checkOutput($sformatf("t5_data%0d", b), capQData[b], mkData(1, 5, b));
        end
        checkOutput("t5_keep2", 256'(capQKeep[2]), 256'(8'h03));
        for (int i = 0; i < 4; i++) step();
        checkOutput("t5_held_tvalid", 256'(tvalid), 256'(1'b0));
        checkOutput("t5_held_dbg", 256'({odbg[3], odbg[0]}), 256'(2'b01));
        checkOutput("t5_held_count", 256'(capQData.size()), 256'(3));
        link = 1'b1;
        waitCaptures(4, 20);
        checkOutput("t5_ch3", capQData[3], mkData(3, 5, 0));

        // Test 6: async reset mid-packet
        tready = 1'b0;
        applyStimulus(0, 6, 30, 5'd0, 1'b0);
        checkOutput("t6_pre_ready", 256'(ch_ready), 256'(4'he));
        checkOutput("t6_pre_valid", 256'(tvalid), 256'(1'b1));
        #2;
        pcie_rst = 1'b1;
        #1;
        checkOutput("t6_rst_tvalid", 256'(tvalid), 256'(1'b0));
        checkOutput("t6_rst_ready", 256'(ch_ready), 256'(4'hf));
        checkOutput("t6_rst_odbg", 256'(odbg), 256'(16'h0000));
        step();
        pcie_rst = 1'b0;
        tready = 1'b1;
        clearCaps();
        applyStimulus(2, 7, 2, 5'd0, 1'b0);
        waitCaptures(2, 20);
        checkOutput("t6_data0", capQData[0], mkData(2, 7, 0));
        checkOutput("t6_data1", capQData[1], mkData(2, 7, 1));
        for (int i = 0; i < 5; i++) step();
        checkOutput("t6_no_stale", 256'(capQData.size()), 256'(2));
        checkOutput("t6_pktcnt", 256'(odbg[15:8]), 256'(8'd1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
